truth_table_sweeper: RTL

//  Upstream stimulus/capture stage for a 3-input logic gate (in1,in2,in3 -> out).
//  On start, drives all 8 input combinations in order 000..111, holds each for a

---
 rtl/truth_table_sweeper.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//
// Stimulus/capture stage for a 3-input combinational gate. A start request
// launches a sweep that drives every input row 000..111 onto {in1,in2,in3},
// holds each row for SETTLE_CYCLES clocks, and samples the gate output at the
// end of the window. The samples build an 8-bit signature in which row 000
// lands in bit 7 and row 111 in bit 0. The signature is then compared against
// the expected value that was captured when the sweep was accepted.
//
// Optional feature (macro TT_SWEEP_MAJORITY_EN):
//   defined     - gate_out is sampled on the last three edges of each window
//                 and the stored bit is the 2-of-3 majority of those samples.
//                 SETTLE_CYCLES must be >= 3.
//   not defined - gate_out is sampled once, on the row-change edge.
//
// Parameters:
//   SETTLE_CYCLES  clock cycles each row is held (>= 1, >= 3 with the vote)
//   CNT_W          settle counter width, SETTLE_CYCLES < 2**CNT_W
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   sweep request, accepted only while idle
//   abort      in   cancel a running sweep (no done, results untouched)
//   expected   in   [7:0] expected signature, captured when start is accepted
//   gate_out   in   output of the gate being swept
//   in1        out  gate input MSB of the row index
//   in2        out  gate input middle bit of the row index
//   in3        out  gate input LSB of the row index
//   busy       out  high while a sweep runs
//   done       out  one-cycle pulse when a sweep completes
//   table_sig  out  [7:0] last completed truth-table signature
//   match      out  table_sig equals the captured expected value
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_sig,
  output logic       match
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;

  logic [2:0]       row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       exp_q;
  logic [7:0]       work_q;
  logic [7:0]       work_next;
  logic [7:0]       table_q;
  logic             match_q;
  logic             done_q;

  logic             accept;
  logic             cancel;
  logic             row_step;
  logic             finish;
  logic             window_end;
  logic             sample_bit;

  // The last count of a window is the row-change edge; the sample taken
  // there (or the vote that closes there) belongs to the row being left.
  assign window_end = (cnt_q == CNT_LAST);

`ifdef TT_SWEEP_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_VOTE_A = CNT_W'(SETTLE_CYCLES - 3);
  localparam logic [CNT_W-1:0] CNT_VOTE_B = CNT_W'(SETTLE_CYCLES - 2);

  logic vote_a_q;
  logic vote_b_q;

  // The first two votes are stored; the third is the live gate_out seen on
  // the row-change edge, so the majority resolves with no extra latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_a_q <= 1'b0;
      vote_b_q <= 1'b0;
    end else if (state == SWEEP) begin
      if (cnt_q == CNT_VOTE_A) vote_a_q <= gate_out;
      if (cnt_q == CNT_VOTE_B) vote_b_q <= gate_out;
    end
  end

  assign sample_bit = (vote_a_q & vote_b_q) |
                      (vote_a_q & gate_out) |
                      (vote_b_q & gate_out);
`else
  assign sample_bit = gate_out;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes. Abort is checked before the end of the
  // final window so a same-cycle abort suppresses completion.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cancel     = 1'b0;
    row_step   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SWEEP;
          accept     = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_next = IDLE;
          cancel     = 1'b1;
        end else if (window_end) begin
          if (row_q == 3'd7) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            row_step = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Working signature with the current row's sample merged in; row k maps
  // to bit 7-k so the table reads MSB-first in row order.
  always_comb begin
    work_next                 = work_q;
    work_next[3'd7 - row_q]   = sample_bit;
  end

  // Sweep datapath: row index, settle counter, captured expectation, the
  // working signature and the published results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= 3'd0;
      cnt_q   <= '0;
      exp_q   <= 8'h00;
      work_q  <= 8'h00;
      table_q <= 8'h00;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        row_q  <= 3'd0;
        cnt_q  <= '0;
        exp_q  <= expected;
        work_q <= 8'h00;
      end else if (cancel) begin
        row_q <= 3'd0;
        cnt_q <= '0;
      end else if (state == SWEEP) begin
        if (window_end) begin
          cnt_q  <= '0;
          work_q <= work_next;
          if (finish) begin
            row_q   <= 3'd0;
            table_q <= work_next;
            match_q <= (work_next == exp_q);
          end else if (row_step) begin
            row_q <= row_q + 3'd1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Inputs are forced to 000 whenever no sweep is running.
  assign {in1, in2, in3} = (state == SWEEP) ? row_q : 3'b000;
  assign busy            = (state == SWEEP);
  assign done            = done_q;
  assign table_sig       = table_q;
  assign match           = match_q;

endmodule
